// File: rtl/midi_note_parser_if.sv
// MIDI byte-in / note-out bundle between the UART receiver, the note parser and the oscillator.
// master drives received bytes and channel select; slave is the parser producing note/gate.
interface midi_note_parser_if;
  logic       byte_valid_i;
  logic [7:0] byte_i;
  logic [3:0] channel_i;
  logic [7:0] note_o;
  logic [6:0] velocity_o;
  logic       gate_o;
  logic       note_strobe_o;

  modport master (
    output byte_valid_i, byte_i, channel_i,
    input  note_o, velocity_o, gate_o, note_strobe_o
  );

  modport slave (
    input  byte_valid_i, byte_i, channel_i,
    output note_o, velocity_o, gate_o, note_strobe_o
  );
endinterface

// File: rtl/midi_note_parser.sv
// Monophonic MIDI Note On/Off decoder with running status, feeding the oscillator note/enable.
// Optional MIDI_CHANNEL_FILTER_EN: accept only the selected channel (else omni mode).
module midi_note_parser #(
  parameter logic [3:0] DEFAULT_CH = 4'd0
) (
  input logic               clk_i,
  input logic               nrst_i,
  midi_note_parser_if.slave bus_if
);

  typedef enum logic [2:0] {IDLE, NOTE_D1, NOTE_D2, SKIP_D1, SKIP_D2} state_e;

  state_e     state_q, state_d;
  logic       rs_on_q, rs_on_d;
  logic       rs_two_q, rs_two_d;
  logic [6:0] key_q, key_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       strobe_q, strobe_d;

  logic is_rt, is_sys, is_chan, is_data, own_ch;

  // Real-time bytes (F8-FF) are invisible to the decoder, even mid-message.
  assign is_rt   = bus_if.byte_valid_i && (bus_if.byte_i[7:3] == 5'b11111);
  assign is_sys  = bus_if.byte_valid_i && (bus_if.byte_i[7:3] == 5'b11110);
  assign is_chan = bus_if.byte_valid_i && bus_if.byte_i[7] && (bus_if.byte_i[7:4] != 4'hF);
  assign is_data = bus_if.byte_valid_i && !bus_if.byte_i[7];

`ifdef MIDI_CHANNEL_FILTER_EN
  logic [3:0] chan_q, chan_d;

  assign chan_d = (is_chan || is_sys) ? bus_if.channel_i : chan_q;
  assign own_ch = (bus_if.byte_i[3:0] == chan_d);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) chan_q <= DEFAULT_CH;
    else         chan_q <= chan_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus_if.channel_i, DEFAULT_CH, is_rt};
  assign own_ch     = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      rs_on_q  <= 1'b0;
      rs_two_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs_on_q  <= rs_on_d;
      rs_two_q <= rs_two_d;
    end
  end

  // Foreign-channel note messages still carry two data bytes, so they loop through SKIP_D2.
  always_comb begin
    state_d  = state_q;
    rs_on_d  = rs_on_q;
    rs_two_d = rs_two_q;
    if (is_chan) begin
      unique case (bus_if.byte_i[7:4])
        4'h8, 4'h9: begin
          if (own_ch) begin
            state_d = NOTE_D1;
            rs_on_d = bus_if.byte_i[4];
          end else begin
            state_d  = SKIP_D2;
            rs_two_d = 1'b1;
          end
        end
        4'hC, 4'hD: begin
          state_d  = SKIP_D1;
          rs_two_d = 1'b0;
        end
        default: begin
          state_d  = SKIP_D2;
          rs_two_d = 1'b1;
        end
      endcase
    end else if (is_sys) begin
      state_d = IDLE;
    end else if (is_data) begin
      unique case (state_q)
        NOTE_D1: state_d = NOTE_D2;
        NOTE_D2: state_d = NOTE_D1;
        SKIP_D2: state_d = SKIP_D1;
        SKIP_D1: state_d = rs_two_q ? SKIP_D2 : SKIP_D1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    key_d    = key_q;
    note_d   = note_q;
    vel_d    = vel_q;
    gate_d   = gate_q;
    strobe_d = 1'b0;
    if (is_data && (state_q == NOTE_D1)) begin
      key_d = bus_if.byte_i[6:0];
    end else if (is_data && (state_q == NOTE_D2)) begin
      if (rs_on_q && (bus_if.byte_i[6:0] != 7'd0)) begin
        note_d   = key_q;
        vel_d    = bus_if.byte_i[6:0];
        gate_d   = 1'b1;
        strobe_d = 1'b1;
      end else if (key_q == note_q) begin
        gate_d   = 1'b0;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      key_q    <= 7'd0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus_if.note_o        = {1'b0, note_q};
  assign bus_if.velocity_o    = vel_q;
  assign bus_if.gate_o        = gate_q;
  assign bus_if.note_strobe_o = strobe_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser: note on/off, running status, real-time and reset cases.
module tb_midi_note_parser;

  logic clk_i  = 1'b0;
  logic nrst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   strobe_cnt = 0;
  int   strobe_base = 0;

  midi_note_parser_if bus ();

  midi_note_parser #(.DEFAULT_CH(4'd0)) dut (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .bus_if (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (bus.note_strobe_o === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk_i);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b;
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    @(negedge clk_i);
  endtask

  task automatic applyBurst3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    @(negedge clk_i);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b0;
    @(negedge clk_i);
    bus.byte_i       = b1;
    @(negedge clk_i);
    bus.byte_i       = b2;
    @(negedge clk_i);
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    @(negedge clk_i);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    nrst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);
    strobe_base = strobe_cnt;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] exp_note,
                             input logic [6:0] exp_vel, input logic exp_gate,
                             input int exp_strobes);
    checks++;
    assert (bus.note_o === exp_note) else begin
      errors++;
      $error("[TB] FAIL %s note_o observed=%h expected=%h", tag, bus.note_o, exp_note);
    end
    checks++;
    assert (bus.velocity_o === exp_vel) else begin
      errors++;
      $error("[TB] FAIL %s velocity_o observed=%h expected=%h", tag, bus.velocity_o, exp_vel);
    end
    checks++;
    assert (bus.gate_o === exp_gate) else begin
      errors++;
      $error("[TB] FAIL %s gate_o observed=%b expected=%b", tag, bus.gate_o, exp_gate);
    end
    checks++;
    assert ((strobe_cnt - strobe_base) === exp_strobes) else begin
      errors++;
      $error("[TB] FAIL %s strobes observed=%0d expected=%0d", tag, strobe_cnt - strobe_base,
             exp_strobes);
    end
  endtask

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    bus.channel_i    = 4'd0;
    repeat (2) @(negedge clk_i);
    checks++;
    assert (bus.note_o === 8'h00 && bus.gate_o === 1'b0 && bus.note_strobe_o === 1'b0) else begin
      errors++;
      $error("[TB] FAIL in_reset outputs observed=%h/%b/%b expected=00/0/0",
             bus.note_o, bus.gate_o, bus.note_strobe_o);
    end
    nrst_i = 1'b1;
    @(negedge clk_i);
    strobe_base = strobe_cnt;
    checkOutput("reset", 8'h00, 7'h00, 1'b0, 0);

    // Basic note on, then running status
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("note_on", 8'h3C, 7'h64, 1'b1, 1);
    applyStimulus(8'h40); applyStimulus(8'h50);
    checkOutput("running_status", 8'h40, 7'h50, 1'b1, 2);

    // Note off for other key is ignored; matching key releases
    doReset();
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
    applyStimulus(8'h80); applyStimulus(8'h3E); applyStimulus(8'h00);
    checkOutput("off_other_key", 8'h3C, 7'h64, 1'b1, 1);
    applyStimulus(8'h80); applyStimulus(8'h3C); applyStimulus(8'h00);
    checkOutput("off_match", 8'h3C, 7'h64, 1'b0, 2);

    // Velocity-zero note on as off, then clock byte inside a message
    doReset();
    applyStimulus(8'h90); applyStimulus(8'h3C); applyStimulus(8'h64);
    applyStimulus(8'h3C); applyStimulus(8'h00);
    checkOutput("vel0_off", 8'h3C, 7'h64, 1'b0, 2);
    applyStimulus(8'h90); applyStimulus(8'h30); applyStimulus(8'hF8); applyStimulus(8'h7F);
    checkOutput("realtime_mid", 8'h30, 7'h7F, 1'b1, 3);

    // Non-note messages and system common leave outputs idle
    doReset();
    applyStimulus(8'hB0); applyStimulus(8'h07); applyStimulus(8'h7F);
    applyStimulus(8'hC0); applyStimulus(8'h05);
    applyStimulus(8'hF0); applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("skip_sys", 8'h00, 7'h00, 1'b0, 0);
    applyStimulus(8'h3C); applyStimulus(8'h64);
    checkOutput("idle_data", 8'h00, 7'h00, 1'b0, 0);
    bus.channel_i = 4'd1;
    applyStimulus(8'h91); applyStimulus(8'h48); applyStimulus(8'h40);
    checkOutput("ch1_match", 8'h48, 7'h40, 1'b1, 1);

    doReset();
    bus.channel_i = 4'd0;
    applyStimulus(8'h91); applyStimulus(8'h48); applyStimulus(8'h40);
`ifdef MIDI_CHANNEL_FILTER_EN
    checkOutput("ch0_filter", 8'h00, 7'h00, 1'b0, 0);
`else
    checkOutput("ch0_omni", 8'h48, 7'h40, 1'b1, 1);
`endif

    // Program change running status consumes single data bytes
    doReset();
    applyStimulus(8'hC0); applyStimulus(8'h05); applyStimulus(8'h06); applyStimulus(8'h07);
    applyStimulus(8'h90); applyStimulus(8'h22); applyStimulus(8'h11);
    checkOutput("skip1_then_note", 8'h22, 7'h11, 1'b1, 1);

    // Reset in the middle of a message
    doReset();
    applyStimulus(8'h90); applyStimulus(8'h3C);
    doReset();
    applyStimulus(8'h64);
    checkOutput("reset_mid", 8'h00, 7'h00, 1'b0, 0);

    // Back-to-back valids, then non-matching vel-0 off
    doReset();
    applyBurst3(8'h90, 8'h45, 8'h22);
    checkOutput("back_to_back", 8'h45, 7'h22, 1'b1, 1);
    applyStimulus(8'h44); applyStimulus(8'h00);
    checkOutput("vel0_other_key", 8'h45, 7'h22, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
